// File: rtl/button_event_fsm.sv
// Button event decoder: turns a debounced button level into press, release,
// long-press and auto-repeat pulses, plus a held level and a press counter.
module button_event_fsm #(
    parameter int unsigned LONG_COUNT   = 32'd50_000_000,
    parameter int unsigned REPEAT_COUNT = 32'd10_000_000
) (
    input  logic       CLK50M,
    input  logic       RST_N,
    input  logic       A,
    output logic       PRESS,
    output logic       RELEASE,
    output logic       LONG,
    output logic       REPEAT,
    output logic       HELD,
    output logic [7:0] EVENT_COUNT
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;

    localparam logic [31:0] LONG_LAST   = 32'(LONG_COUNT - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_COUNT - 1);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic        press_q;
    logic        release_q;
    logic        long_q;
    logic        repeat_q;
    logic        held_q;
    logic [7:0]  event_count_q;

    // Releasing the button is tested first in every held state, so a release
    // always beats a coincident LONG or REPEAT terminal count.
    always_ff @(posedge CLK50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            held_q        <= 1'b0;
            event_count_q <= '0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (A) begin
                        state_q       <= PRESSED;
                        press_q       <= 1'b1;
                        held_q        <= 1'b1;
                        event_count_q <= event_count_q + 8'd1;
                    end
                end
                PRESSED: begin
                    if (!A) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= LONG_HELD;
                        long_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                LONG_HELD: begin
                    if (!A) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    held_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign PRESS       = press_q;
    assign RELEASE     = release_q;
    assign LONG        = long_q;
    assign REPEAT      = repeat_q;
    assign HELD        = held_q;
    assign EVENT_COUNT = event_count_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed self-checking bench for button_event_fsm with short LONG/REPEAT
// counts so hold, long-press, auto-repeat and wrap behaviour fit in a short run.
module tb_button_event_fsm;

    localparam int unsigned LONG_C   = 10;
    localparam int unsigned REPEAT_C = 4;

    logic       CLK50M;
    logic       RST_N;
    logic       A;
    logic       PRESS;
    logic       RELEASE;
    logic       LONG;
    logic       REPEAT;
    logic       HELD;
    logic [7:0] EVENT_COUNT;

    int compareCount  = 0;
    int mismatchCount = 0;

    button_event_fsm #(
        .LONG_COUNT  (LONG_C),
        .REPEAT_COUNT(REPEAT_C)
    ) dut (
        .CLK50M     (CLK50M),
        .RST_N      (RST_N),
        .A          (A),
        .PRESS      (PRESS),
        .RELEASE    (RELEASE),
        .LONG       (LONG),
        .REPEAT     (REPEAT),
        .HELD       (HELD),
        .EVENT_COUNT(EVENT_COUNT)
    );

    initial begin
        CLK50M = 1'b0;
        forever #5 CLK50M = ~CLK50M;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Output bundle ordered {PRESS, RELEASE, LONG, REPEAT, HELD}.
    function automatic logic [4:0] outVec();
        return {PRESS, RELEASE, LONG, REPEAT, HELD};
    endfunction

    task automatic applyStimulus(input logic aVal);
        A = aVal;
        @(posedge CLK50M);
        #1;
    endtask

    // Pulse exclusivity is checked every cycle outside reset.
    always @(negedge CLK50M) begin
        if (RST_N === 1'b1)
            checkOutput("onehot0", 32'($onehot0({PRESS, RELEASE, LONG, REPEAT})), 32'd1);
    end

    // Hold for holdCycles edges then release: PRESS at 0, LONG at LONG_C,
    // REPEAT every REPEAT_C after that, RELEASE at holdCycles wins any tie.
    task automatic holdScenario(input string name, input int holdCycles);
        logic [4:0] expVec;
        for (int i = 0; i <= holdCycles; i++) begin
            applyStimulus(i < holdCycles);
            expVec = '0;
            expVec[0] = (i < holdCycles);
            if (i == 0)
                expVec[4] = 1'b1;
            else if (i == holdCycles)
                expVec[3] = 1'b1;
            else if (i == LONG_C)
                expVec[2] = 1'b1;
            else if (i > LONG_C && ((i - LONG_C) % REPEAT_C) == 0)
                expVec[1] = 1'b1;
            checkOutput($sformatf("%s_c%0d", name, i), 32'(outVec()), 32'(expVec));
        end
    endtask

    task automatic pulseReset();
        #3;
        RST_N = 1'b0;
        #1;
        checkOutput("rst_async_outs", 32'(outVec()), 32'd0);
        checkOutput("rst_async_evt", 32'(EVENT_COUNT), 32'd0);
        @(posedge CLK50M);
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b1;
        A     = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("reset_outs", 32'(outVec()), 32'd0);
        checkOutput("reset_evt", 32'(EVENT_COUNT), 32'd0);
        @(posedge CLK50M);
        #2;
        RST_N = 1'b1;

        applyStimulus(1'b0);
        checkOutput("idle_outs", 32'(outVec()), 32'd0);
        applyStimulus(1'b0);
        checkOutput("idle_evt", 32'(EVENT_COUNT), 32'd0);

        // Short press of 5 cycles.
        holdScenario("short5", 5);
        checkOutput("short5_evt", 32'(EVENT_COUNT), 32'd1);

        // Long hold of 20 cycles: LONG at 10, REPEAT at 14 and 18, RELEASE at 20.
        holdScenario("hold20", 20);
        checkOutput("hold20_evt", 32'(EVENT_COUNT), 32'd2);

        // Release exactly where LONG would have fired.
        holdScenario("dropLong", 10);
        // Release exactly where the first REPEAT would have fired.
        holdScenario("dropRep", 14);
        checkOutput("drop_evt", 32'(EVENT_COUNT), 32'd4);

        // 256 one-cycle presses from a clean count: 1-0-1 gives PRESS/RELEASE back to back.
        pulseReset();
        applyStimulus(1'b0);
        begin
            int pressSeen = 0;
            int releaseSeen = 0;
            for (int k = 0; k < 256; k++) begin
                applyStimulus(1'b1);
                pressSeen += int'(PRESS);
                if (k == 254)
                    checkOutput("wrap_255", 32'(EVENT_COUNT), 32'd255);
                applyStimulus(1'b0);
                releaseSeen += int'(RELEASE);
            end
            checkOutput("burst_press_cnt", 32'(pressSeen), 32'd256);
            checkOutput("burst_release_cnt", 32'(releaseSeen), 32'd256);
            checkOutput("burst_evt_wrap", 32'(EVENT_COUNT), 32'd0);
        end

        // Reset mid LONG_HELD with A kept high: no RELEASE, PRESS at first edge after.
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1);
        checkOutput("lh_held", 32'(HELD), 32'd1);
        pulseReset();
        checkOutput("lh_in_reset", 32'(outVec()), 32'd0);
        applyStimulus(1'b1);
        checkOutput("lh_repress", 32'(outVec()), 32'b10001);
        checkOutput("lh_repress_evt", 32'(EVENT_COUNT), 32'd1);
        applyStimulus(1'b0);
        checkOutput("lh_release", 32'(outVec()), 32'b01000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/button_event_fsm.md
BUTTON_EVENT_FSM -- requirements
Module: button_event_fsm

Interface
REQ-001 The block SHALL have parameter LONG_COUNT, default 50_000_000, giving the cycles held in PRESSED before LONG (1 s at 50 MHz); legal range 2..2^32-1.
REQ-002 The block SHALL have parameter REPEAT_COUNT, default 10_000_000, giving the cycles between REPEAT pulses in LONG_HELD (200 ms); legal range 1..2^32-1.
REQ-003 The block SHALL have port CLK50M  input  1  50 MHz clock; the only clock.
REQ-004 The block SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port A  input  1  debounced button level, 1 = pressed, synchronous to CLK50M.
REQ-006 The block SHALL have port PRESS  output  1  one-cycle pulse on press.
REQ-007 The block SHALL have port RELEASE  output  1  one-cycle pulse on release.
REQ-008 The block SHALL have port LONG  output  1  one-cycle pulse when a hold reaches LONG_COUNT.
REQ-009 The block SHALL have port REPEAT  output  1  one-cycle auto-repeat pulse while long-held.
REQ-010 The block SHALL have port HELD  output  1  level, 1 whenever the state is not IDLE.
REQ-011 The block SHALL have port EVENT_COUNT  output  8  number of PRESS pulses issued, modulo 256.

Function
REQ-012 The block SHALL implement states IDLE, PRESSED and LONG_HELD, plus one 32-bit unsigned cycle counter CNT.
REQ-013 All outputs SHALL be registered; every pulse SHALL be high for exactly one cycle, starting at the clock edge where its transition occurs.
REQ-014 IDLE with A=1 at an edge SHALL go to PRESSED, set PRESS=1, set CNT=0, and increment EVENT_COUNT.
REQ-015 IDLE with A=0 SHALL hold state, keep CNT=0, and leave all pulses low.
REQ-016 PRESSED with A=0 SHALL go to IDLE, set RELEASE=1 and set CNT=0.
REQ-017 PRESSED with A=1 and CNT=LONG_COUNT-1 SHALL go to LONG_HELD, set LONG=1 and set CNT=0; LONG therefore rises exactly LONG_COUNT cycles after PRESS.
REQ-018 PRESSED with A=1 and CNT<LONG_COUNT-1 SHALL increment CNT.
REQ-019 LONG_HELD with A=1 and CNT=REPEAT_COUNT-1 SHALL set REPEAT=1, set CNT=0 and stay in LONG_HELD; REPEAT pulses SHALL recur every REPEAT_COUNT cycles, the first REPEAT_COUNT cycles after LONG.
REQ-020 LONG_HELD with A=1 and CNT<REPEAT_COUNT-1 SHALL increment CNT.
REQ-021 LONG_HELD with A=0 SHALL go to IDLE, set RELEASE=1 and set CNT=0.
REQ-022 When A=0 coincides with a terminal count, release SHALL win: RELEASE=1 and LONG and REPEAT stay 0.
REQ-023 EVENT_COUNT SHALL wrap from 255 to 0 with no flag.
REQ-024 A 1-0-1 sequence on A with one cycle per level SHALL produce PRESS, then RELEASE, then PRESS, in consecutive cycles.
REQ-025 At most one of PRESS, RELEASE, LONG and REPEAT SHALL be high in any cycle.

Reset
REQ-026 RST_N=0 SHALL immediately, without waiting for a clock edge, force state IDLE, CNT=0, PRESS=RELEASE=LONG=REPEAT=HELD=0 and EVENT_COUNT=0.
REQ-027 Reset asserted mid-hold SHALL give no RELEASE pulse; after reset deasserts with A still 1, the next edge SHALL produce PRESS.
REQ-028 Reset deassertion is synchronised externally to CLK50M; the block SHALL leave IDLE no earlier than the first edge after deassertion.

Verification (LONG_COUNT=10, REPEAT_COUNT=4)
REQ-029 Press A for 5 cycles then release -> PRESS at edge 0, RELEASE at edge 5, no LONG, EVENT_COUNT=1, HELD high for 5 cycles.
REQ-030 Hold A for 20 cycles -> PRESS at t0, LONG at t0+10, REPEAT at t0+14 and t0+18, RELEASE at t0+20.
REQ-031 Drop A at the edge where CNT=9 in PRESSED -> RELEASE only, LONG never asserted.
REQ-032 Apply 256 one-cycle presses separated by one low cycle -> 256 PRESS pulses and 256 RELEASE pulses, EVENT_COUNT ends at 0.
REQ-033 Assert RST_N=0 between clock edges during LONG_HELD -> all outputs 0 immediately; with A=1 after deassertion, PRESS at the first edge and EVENT_COUNT=1.
REQ-034 Check every cycle with an assertion -> pulses are mutually exclusive (one-hot or zero), and HELD equals (state != IDLE).
